// File: rtl/serial_add_sequencer.sv
// Bit-serial adder/subtractor: one full-adder cell (two half adders) is reused
// across all WIDTH bit positions under a start/busy/done handshake.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_c,
  output logic c_c
);
  assign s_c = a_i ^ b_i;
  assign c_c = a_i & b_i;
endmodule

module serial_add_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic ha0_s_c, ha0_c_c, ha1_s_c, ha1_c_c, fa_s_c, fa_c_c;

  // Shared full-adder cell: operand LSBs plus the running carry
  half_adder u_ha0 (.a_i(opa_q[0]), .b_i(opb_q[0]), .s_c(ha0_s_c), .c_c(ha0_c_c));
  half_adder u_ha1 (.a_i(ha0_s_c),  .b_i(carry_q),  .s_c(ha1_s_c), .c_c(ha1_c_c));

  assign fa_s_c = ha1_s_c;
  assign fa_c_c = ha0_c_c | ha1_c_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtract as a + ~b + 1: invert B and seed the carry with 1
          state_d = S_RUN;
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      S_RUN: begin
        res_d   = {fa_s_c, res_q[WIDTH-1:1]};
        carry_d = fa_c_c;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          sum_d   = {fa_s_c, res_q[WIDTH-1:1]};
          cout_d  = fa_c_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and randomized checks of serial_add_sequencer at WIDTH 8, 2 and 32
// against an arithmetic reference model.

module tb_serial_add_sequencer;
  logic clk = 1'b0;
  logic rst_n;

  logic        start8, sub8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start2, sub2, busy2, done2, cout2;
  logic [1:0]  a2, b2, sum2;
  logic        start32, sub32, busy32, done32, cout32;
  logic [31:0] a32, b32, sum32;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_add_sequencer #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );
  serial_add_sequencer #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic st, input logic [31:0] av,
                       input logic [31:0] bv, input logic sb);
    case (inst)
      0: begin start8 = st; a8 = 8'(av); b8 = 8'(bv); sub8 = sb; end
      1: begin start2 = st; a2 = 2'(av); b2 = 2'(bv); sub2 = sb; end
      default: begin start32 = st; a32 = av; b32 = bv; sub32 = sb; end
    endcase
  endtask

  task automatic sample(input int inst, output logic bz, output logic dn,
                        output logic [31:0] s, output logic co);
    case (inst)
      0: begin bz = busy8; dn = done8; s = 32'(sum8); co = cout8; end
      1: begin bz = busy2; dn = done2; s = 32'(sum2); co = cout2; end
      default: begin bz = busy32; dn = done32; s = sum32; co = cout32; end
    endcase
  endtask

  // Counts falling edges until done is seen (bounded)
  task automatic wait_done(input int inst, input int lat0, output int lat);
    logic bz, dn, co;
    logic [31:0] s;
    lat = lat0;
    sample(inst, bz, dn, s, co);
    while (!dn && lat < 200) begin
      @(negedge clk);
      lat++;
      sample(inst, bz, dn, s, co);
    end
  endtask

  task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic sb, output logic [63:0] es, output logic [63:0] ec);
    longint unsigned m, ea, eb, tot;
    m  = (longint'(1) << w) - 1;
    ea = longint'(av) & m;
    eb = longint'(bv) & m;
    if (!sb) begin
      tot = ea + eb;
      es  = tot & m;
      ec  = tot >> w;
    end else begin
      es = (ea - eb) & m;
      ec = (ea >= eb) ? 64'd1 : 64'd0;
    end
  endtask

  task automatic run_op(input int inst, input int w, input logic [31:0] av,
                        input logic [31:0] bv, input logic sb, input string tag);
    logic [63:0] es, ec;
    logic bz, dn, co;
    logic [31:0] s;
    int lat;
    model(w, av, bv, sb, es, ec);
    @(negedge clk);
    drive(inst, 1'b1, av, bv, sb);
    @(negedge clk);
    drive(inst, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
    wait_done(inst, 0, lat);
    sample(inst, bz, dn, s, co);
    chk({tag, "_lat"}, 64'(lat), 64'(w));
    chk({tag, "_sum"}, 64'(s), es);
    chk({tag, "_cout"}, 64'(co), ec);
    @(negedge clk);
    sample(inst, bz, dn, s, co);
    chk({tag, "_done_pulse"}, 64'({bz, dn}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bz, dn, co, hold_ok;
    logic [31:0] s;
    int lat, ndone, gap;

    rst_n = 1'b0;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    drive(2, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    sample(0, bz, dn, s, co);
    chk("reset_outputs", 64'({bz, dn, co, s}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 8, 32'h5A, 32'h3C, 1'b0, "add_5a_3c");
    run_op(0, 8, 32'hFF, 32'h01, 1'b0, "add_ovf");
    run_op(0, 8, 32'h10, 32'h01, 1'b1, "sub_10_01");
    run_op(0, 8, 32'h00, 32'h01, 1'b1, "sub_borrow");
    sample(0, bz, dn, s, co);
    chk("hold_after_done", 64'({co, s}), 64'h0_0000_00FF);

    // start during RUN must be ignored
    @(negedge clk);
    drive(0, 1'b1, 32'h01, 32'h01, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    drive(0, 1'b1, 32'hAA, 32'h55, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 1'b0);
    wait_done(0, 3, lat);
    sample(0, bz, dn, s, co);
    chk("ignore_lat", 64'(lat), 64'd8);
    chk("ignore_sum", 64'(s), 64'h02);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      sample(0, bz, dn, s, co);
      if (dn) ndone++;
    end
    chk("ignore_extra_done", 64'(ndone), 64'd0);
    chk("ignore_idle", 64'({bz, s}), 64'h02);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    drive(0, 1'b1, 32'h7F, 32'h01, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 sample(0, bz, dn, s, co);
    chk("rst_async_outputs", 64'({bz, dn, co, s}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      sample(0, bz, dn, s, co);
      if (dn || bz) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'd0);
    chk("rst_sum_zero", 64'(s), 64'd0);
    run_op(0, 8, 32'h03, 32'h04, 1'b0, "post_reset");

    // start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge clk);
    drive(0, 1'b1, 32'h11, 32'h22, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 32'h40, 32'h40, 1'b0);
    wait_done(0, 0, lat);
    sample(0, bz, dn, s, co);
    chk("b2b_lat", 64'(lat), 64'd8);
    chk("b2b_sum1", 64'(s), 64'h33);
    gap = 0;
    hold_ok = 1'b1;
    do begin
      @(negedge clk);
      gap++;
      sample(0, bz, dn, s, co);
      if (!dn && s != 32'h33) hold_ok = 1'b0;
    end while (!dn && gap < 100);
    drive(0, 1'b0, 0, 0, 1'b0);
    chk("b2b_gap", 64'(gap), 64'd10);
    chk("b2b_hold", 64'(hold_ok), 64'd1);
    chk("b2b_sum2", 64'({co, s}), 64'h80);
    repeat (2) @(negedge clk);
    sample(0, bz, dn, s, co);
    chk("b2b_idle", 64'({bz, dn}), 64'd0);

    // Randomized sweep across widths
    for (int i = 0; i < 12; i++) begin
      run_op(1, 2, $urandom, $urandom, 1'($urandom_range(0, 1)), "rand_w2");
      run_op(2, 32, $urandom, $urandom, 1'($urandom_range(0, 1)), "rand_w32");
      run_op(0, 8, $urandom, $urandom, 1'($urandom_range(0, 1)), "rand_w8");
    end
    run_op(2, 32, 32'hFFFF_FFFF, 32'h1, 1'b0, "w32_ovf");
    run_op(2, 32, 32'h0, 32'h1, 1'b1, "w32_borrow");
    run_op(1, 2, 32'h3, 32'h3, 1'b0, "w2_ovf");
    run_op(1, 2, 32'h1, 32'h2, 1'b1, "w2_borrow");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
